serial_receiver_frame_assembler: RTL and testbench
==================================================

SERIAL_RECEIVER_FRAME_ASSEMBLER -- requirements
Module: serial_receiver_frame_assembler

Interface
REQ-001 Parameter FRAME_BYTES, default 16, SHALL set the number of bytes per frame (legal range 2..64).
REQ-002 clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset_i  input  1  SHALL be a synchronous, active-high reset.
REQ-004 rx_data_i  input  8  SHALL carry a received byte from the UART receiver.
REQ-005 rx_valid_i  input  1  SHALL be a one-cycle strobe qualifying rx_data_i; there is no backpressure.
REQ-006 timed_out_i  input  1  SHALL be the level output of the serial receiver timeout timer.
REQ-007 timer_reset_o  output  1  SHALL drive the timeout timer's reset input.
REQ-008 frame_o  output  8*FRAME_BYTES  SHALL present the assembled frame.
REQ-009 frame_valid_o  output  1  SHALL qualify frame_o.
REQ-010 frame_ready_i  input  1  SHALL be the downstream acceptance signal.
REQ-011 overrun_o  output  1  SHALL pulse for one cycle when a byte is dropped.

Function
REQ-012 States: IDLE (no bytes held), COLLECT (1..FRAME_BYTES-1 bytes held), HOLD (full frame presented).
REQ-013 Accept = rx_valid_i high in IDLE or COLLECT; on accept the byte SHALL be stored and byte_count incremented.
REQ-014 The first byte of a frame SHALL occupy frame_o[8*FRAME_BYTES-1 -: 8], with later bytes at descending positions.
REQ-015 IDLE -> COLLECT on accept; COLLECT -> HOLD on the accept that brings byte_count to FRAME_BYTES.
REQ-016 frame_valid_o SHALL be high in the cycle after the last byte is accepted, i.e. one-cycle latency.
REQ-017 In HOLD, frame_o and frame_valid_o SHALL stay stable until frame_valid_o and frame_ready_i are both high; HOLD -> IDLE on the following edge with byte_count = 0.
REQ-018 timer_reset_o SHALL be combinational: reset_i OR accept OR (state == HOLD).
REQ-019 timed_out_i SHALL be honoured only in COLLECT; it is ignored in IDLE and HOLD.
REQ-020 COLLECT with timed_out_i high and no accept -> IDLE: partial frame discarded, byte_count = 0, frame_o unchanged.
REQ-021 Accept and timed_out_i high in the same COLLECT cycle: the accept SHALL win, and the byte is stored.
REQ-022 rx_valid_i in HOLD SHALL drop the byte and pulse overrun_o in the next cycle, including the handshake cycle.
REQ-023 byte_count SHALL be $clog2(FRAME_BYTES+1) bits wide and SHALL never exceed FRAME_BYTES.

Reset
REQ-024 reset_i SHALL force IDLE, byte_count = 0, frame_valid_o = 0, overrun_o = 0 and frame_o = 0 on the next edge, from any state.
REQ-025 Reset mid-COLLECT or mid-HOLD SHALL discard all held bytes; an rx_valid_i in the reset cycle SHALL be ignored.
REQ-026 timer_reset_o SHALL be high throughout reset.

Configuration
REQ-027 Macro SERIAL_RECEIVER_DROP_COUNT_EN defined: the block SHALL add output drop_count_o [7:0], an 8-bit counter saturating at 255 and cleared by reset, incremented on each REQ-020 discard and each REQ-022 overrun. If both events occur in one cycle, the counter SHALL increment by 1.
REQ-028 Macro not defined: drop_count_o and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-029 FRAME_BYTES=4, bytes 0xA1,0xB2,0xC3,0xD4 each 10 cycles apart, frame_ready_i=1 -> frame_o=0xA1B2C3D4 with frame_valid_o high exactly 1 cycle, then IDLE.
REQ-030 Send 2 bytes, hold timed_out_i=1 for 1 cycle, then send 4 new bytes 0x01..0x04 -> frame_o=0x01020304, drop_count_o=1 (macro on).
REQ-031 Full frame with frame_ready_i=0 for 20 cycles, rx_valid_i pulsed twice -> frame_o stable, 2 overrun_o pulses, drop_count_o=2.
REQ-032 rx_valid_i and timed_out_i high together in COLLECT -> byte stored, timer_reset_o=1 that cycle, no discard.
REQ-033 reset_i for 1 cycle after 3 of 4 bytes, then 4 bytes 0x11..0x14 -> frame_o=0x11121314, drop_count_o=0.
REQ-034 Force 300 timeouts with partial frames -> drop_count_o saturates at 255.

Source files
------------

// File: rtl/serial_receiver_frame_assembler.sv
// Serial receiver frame assembler.
// Collects FRAME_BYTES bytes from a UART receiver into one frame and holds
// it until downstream accepts it. It discards a partial frame when the
// receiver timeout timer expires, and it flags bytes that arrive while a
// full frame is still waiting.
// Optional feature: define SERIAL_RECEIVER_DROP_COUNT_EN to add drop_count_o,
// a saturating count of discarded partial frames and overrun bytes.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no bytes held
// COLLECT | 1..FRAME_BYTES-1 bytes held
// HOLD    | full frame presented on frame_o
module serial_receiver_frame_assembler #(
  parameter int FRAME_BYTES = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  input  logic                     timed_out_i,
  output logic                     timer_reset_o,
  output logic [8*FRAME_BYTES-1:0] frame_o,
  output logic                     frame_valid_o,
  input  logic                     frame_ready_i,
  output logic                     overrun_o
`ifdef SERIAL_RECEIVER_DROP_COUNT_EN
  ,output logic [7:0]              drop_count_o
`endif
);

  localparam int CNT_W = $clog2(FRAME_BYTES + 1);
  localparam int FW    = 8 * FRAME_BYTES;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CNT_W-1:0] byte_count_q;
  // Bytes received so far, oldest in the upper bits. frame_o is loaded only
  // when the frame completes, so a discarded partial frame never reaches it.
  logic [FW-9:0]   shift_q;
  logic [FW-1:0]   frame_q;
  logic [FW-1:0]   assembled;
  logic            overrun_q;
  logic            accept;
  logic            last_byte;
  logic            discard;
  logic            handshake;

  assign accept    = rx_valid_i && (state_q != S_HOLD);
  assign last_byte = accept && (byte_count_q == CNT_W'(FRAME_BYTES - 1));
  assign discard   = (state_q == S_COLLECT) && timed_out_i && !rx_valid_i;
  assign handshake = (state_q == S_HOLD) && frame_ready_i;
  assign assembled = {shift_q, rx_data_i};

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; an accept takes priority over a timeout in COLLECT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (last_byte)   state_d = S_HOLD;
        else if (accept) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (last_byte)        state_d = S_HOLD;
        else if (accept)      state_d = S_COLLECT;
        else if (timed_out_i) state_d = S_IDLE;
      end
      S_HOLD: begin
        if (frame_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the timer is held in reset while a frame waits
  always_comb begin
    frame_valid_o = (state_q == S_HOLD);
    timer_reset_o = reset_i || accept || (state_q == S_HOLD);
  end

  // Byte storage, frame capture, byte count and overrun flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      byte_count_q <= '0;
      shift_q      <= '0;
      frame_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= (state_q == S_HOLD) && rx_valid_i;
      if (accept) begin
        shift_q      <= assembled[FW-9:0];
        byte_count_q <= byte_count_q + 1'b1;
      end
      if (last_byte) frame_q <= assembled;
      if (discard || handshake) byte_count_q <= '0;
    end
  end

  assign frame_o   = frame_q;
  assign overrun_o = overrun_q;

`ifdef SERIAL_RECEIVER_DROP_COUNT_EN
  logic [7:0] drop_count_q;
  logic       drop_event;

  // Discards and overruns cannot coincide, but a shared strobe guarantees +1 per cycle
  assign drop_event = discard || ((state_q == S_HOLD) && rx_valid_i);

  // Saturating drop counter
  always_ff @(posedge clk_i) begin
    if (reset_i)                              drop_count_q <= 8'd0;
    else if (drop_event && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
  end

  assign drop_count_o = drop_count_q;
`endif

endmodule

// File: tb/tb_serial_receiver_frame_assembler.sv
// Testbench for serial_receiver_frame_assembler (FRAME_BYTES = 4).
// drop_count_o is connected and checked only when
// SERIAL_RECEIVER_DROP_COUNT_EN is defined.
module tb_serial_receiver_frame_assembler;

  localparam int FB = 4;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [7:0]    rx_data_i = 8'h00;
  logic          rx_valid_i = 1'b0;
  logic          timed_out_i = 1'b0;
  logic          timer_reset_o;
  logic [8*FB-1:0] frame_o;
  logic          frame_valid_o;
  logic          frame_ready_i = 1'b0;
  logic          overrun_o;
`ifdef SERIAL_RECEIVER_DROP_COUNT_EN
  logic [7:0]    drop_count_o;
`endif

  serial_receiver_frame_assembler #(.FRAME_BYTES(FB)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .rx_data_i     (rx_data_i),
    .rx_valid_i    (rx_valid_i),
    .timed_out_i   (timed_out_i),
    .timer_reset_o (timer_reset_o),
    .frame_o       (frame_o),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (frame_ready_i),
    .overrun_o     (overrun_o)
`ifdef SERIAL_RECEIVER_DROP_COUNT_EN
    ,.drop_count_o (drop_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes of the frame in progress, the last completed
  // frame, whether it is still waiting, and the event counters.
  byte unsigned pending[$];
  logic [8*FB-1:0] m_frame = '0;
  bit              m_waiting = 1'b0;
  bit              m_overrun = 1'b0;
  int              m_drops = 0;
  int              overrun_pulses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit t, input bit r, input bit rs);
    bit exp_tr;
    @(negedge clk_i);
    rx_valid_i    = v;
    rx_data_i     = d;
    timed_out_i   = t;
    frame_ready_i = r;
    reset_i       = rs;
    #1;
    exp_tr = rs || m_waiting || v;
    chk("timer_reset", {63'd0, timer_reset_o}, {63'd0, exp_tr});
    @(posedge clk_i);
    if (rs) begin
      pending.delete();
      m_frame   = '0;
      m_waiting = 1'b0;
      m_overrun = 1'b0;
      m_drops   = 0;
    end else if (m_waiting) begin
      m_overrun = v;
      if (v && m_drops < 255) m_drops++;
      if (r) m_waiting = 1'b0;
    end else begin
      m_overrun = 1'b0;
      if (v) begin
        pending.push_back(d);
        if (pending.size() == FB) begin
          for (int i = 0; i < FB; i++) m_frame[8*(FB-1-i) +: 8] = pending[i];
          pending.delete();
          m_waiting = 1'b1;
        end
      end else if (t && pending.size() > 0) begin
        pending.delete();
        if (m_drops < 255) m_drops++;
      end
    end
    #1;
    if (overrun_o === 1'b1) overrun_pulses++;
    chk("frame_valid", {63'd0, frame_valid_o}, {63'd0, m_waiting});
    chk("frame", {32'd0, frame_o}, {32'd0, m_frame});
    chk("overrun", {63'd0, overrun_o}, {63'd0, m_overrun});
`ifdef SERIAL_RECEIVER_DROP_COUNT_EN
    chk("drop_count", {56'd0, drop_count_o}, 64'(m_drops));
`endif
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, r, 0);
  endtask

  initial begin
    // Reset
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk("reset_frame", {32'd0, frame_o}, 64'd0);
    chk("reset_valid", {63'd0, frame_valid_o}, 64'd0);

    // Four bytes ten cycles apart, downstream always ready
    step(1, 8'hA1, 0, 1, 0); idle(9, 1);
    step(1, 8'hB2, 0, 1, 0); idle(9, 1);
    step(1, 8'hC3, 0, 1, 0); idle(9, 1);
    step(1, 8'hD4, 0, 1, 0);
    chk("frame_a1b2c3d4", {32'd0, frame_o}, 64'hA1B2C3D4);
    chk("valid_after_last", {63'd0, frame_valid_o}, 64'd1);
    idle(1, 1);
    chk("valid_one_cycle", {63'd0, frame_valid_o}, 64'd0);
    idle(2, 1);

    // Partial frame dropped by timeout, then a fresh frame
    step(1, 8'hEE, 0, 1, 0);
    step(1, 8'hEF, 0, 1, 0);
    step(0, 8'h00, 1, 1, 0);
    chk("frame_kept_on_discard", {32'd0, frame_o}, 64'hA1B2C3D4);
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0, 0);
    chk("frame_01020304", {32'd0, frame_o}, 64'h01020304);
    // Held frame with two overruns, then handshake
    overrun_pulses = 0;
    for (int i = 0; i < 20; i++) step((i == 5 || i == 12), 8'h5A, 0, 0, 0);
    chk("overrun_pulses", 64'(overrun_pulses), 64'd2);
    chk("frame_stable", {32'd0, frame_o}, 64'h01020304);
    step(1, 8'h77, 0, 1, 0);   // byte during handshake cycle is dropped
    idle(2, 0);

    // Accept and timeout together in COLLECT: byte kept
    step(1, 8'h21, 0, 0, 0);
    step(1, 8'h22, 1, 0, 0);
    step(1, 8'h23, 0, 0, 0);
    step(1, 8'h24, 0, 1, 0);
    chk("frame_accept_wins", {32'd0, frame_o}, 64'h21222324);
    idle(2, 0);

    // Reset after three bytes, then a full frame
    step(1, 8'h31, 0, 0, 0);
    step(1, 8'h32, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    step(1, 8'h99, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 8'h11 + 8'(i), 0, 0, 0);
    chk("frame_11121314", {32'd0, frame_o}, 64'h11121314);
    step(0, 8'h00, 0, 1, 0);
    idle(1, 0);

    // 300 timeouts of partial frames: counter saturates
    for (int i = 0; i < 300; i++) begin
      step(1, 8'($urandom), 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
    end
    chk("model_saturated", 64'(m_drops), 64'd255);

    // Randomised traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(2, 0) == 0, 8'($urandom), $urandom_range(7, 0) == 0,
           $urandom_range(1, 0) == 1, $urandom_range(199, 0) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog observed timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
